demux12_router: RTL



---
 rtl/demux12_pkg.sv | 7 +
 rtl/demux12_router_if.sv | 32 +++
 rtl/fwft_fifo.sv | 61 ++++++
 rtl/demux12_router.sv | 83 ++++++++
 4 files changed

// File: rtl/demux12_pkg.sv
// Shared constants for the demux12 router: select encoding and default sizing.
package demux12_pkg;
    localparam logic SEL_A     = 1'b1;
    localparam logic SEL_B     = 1'b0;
    localparam int   DEF_WIDTH = 16;
    localparam int   DEF_DEPTH = 4;
endpackage

// File: rtl/demux12_router_if.sv
// Source stream plus the two destination streams of the demux12 router.
interface demux12_router_if
    import demux12_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_data;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] b_data;
    logic             b_valid;
    logic             b_ready;
    logic [AW:0]      a_count;
    logic [AW:0]      b_count;

    modport master (
        output in_data, in_sel, in_valid, a_ready, b_ready,
        input  in_ready, a_data, a_valid, b_data, b_valid, a_count, b_count
    );

    modport slave (
        input  in_data, in_sel, in_valid, a_ready, b_ready,
        output in_ready, a_data, a_valid, b_data, b_valid, a_count, b_count
    );
endinterface

// File: rtl/fwft_fifo.sv
// First-word-fall-through FIFO: head word read straight from storage, no output register.
module fwft_fifo #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    // A full FIFO refuses a push even if a pop happens in the same cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end
endmodule

// File: rtl/demux12_router.sv
// 1-to-2 stream router with a FWFT FIFO per destination.
// Define DEMUX12_ROUTER_STATS_EN to add per-destination push totals and a stall flag.
module demux12_router
    import demux12_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input logic              clk,
    input logic              reset,
    demux12_router_if.slave  bus
`ifdef DEMUX12_ROUTER_STATS_EN
    ,
    output logic [15:0]      a_total,
    output logic [15:0]      b_total,
    output logic             drop_stall
`endif
);
    logic full_a, full_b;
    logic empty_a, empty_b;
    logic push_a, push_b;
    logic in_ready;

    // Readiness depends only on the selected FIFO's full flag, never on the consumers.
    assign in_ready     = (bus.in_sel == SEL_A) ? ~full_a : ~full_b;
    assign bus.in_ready = in_ready;
    assign push_a       = bus.in_valid & in_ready & (bus.in_sel == SEL_A);
    assign push_b       = bus.in_valid & in_ready & (bus.in_sel == SEL_B);
    assign bus.a_valid  = ~empty_a;
    assign bus.b_valid  = ~empty_b;

    fwft_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
        .clk   (clk),
        .reset (reset),
        .push  (push_a),
        .wdata (bus.in_data),
        .pop   (bus.a_ready),
        .rdata (bus.a_data),
        .empty (empty_a),
        .full  (full_a),
        .count (bus.a_count)
    );

    fwft_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
        .clk   (clk),
        .reset (reset),
        .push  (push_b),
        .wdata (bus.in_data),
        .pop   (bus.b_ready),
        .rdata (bus.b_data),
        .empty (empty_b),
        .full  (full_b),
        .count (bus.b_count)
    );

`ifdef DEMUX12_ROUTER_STATS_EN
    logic [15:0] a_total_q, a_total_d;
    logic [15:0] b_total_q, b_total_d;
    logic        drop_stall_q, drop_stall_d;

    always_comb begin
        a_total_d    = a_total_q + 16'(push_a);
        b_total_d    = b_total_q + 16'(push_b);
        drop_stall_d = bus.in_valid & ~in_ready;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_total_q    <= '0;
            b_total_q    <= '0;
            drop_stall_q <= 1'b0;
        end else begin
            a_total_q    <= a_total_d;
            b_total_q    <= b_total_d;
            drop_stall_q <= drop_stall_d;
        end
    end

    assign a_total    = a_total_q;
    assign b_total    = b_total_q;
    assign drop_stall = drop_stall_q;
`endif
endmodule
